vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_mem_arbiter_if.sv | 41 ++++
 rtl/vga_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle for the VGA screen-RAM arbiter: video fetch port, CPU access
// port, the shared single-port RAM port and the CPU starvation flag.
interface vga_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          cpu_starved;

    // Arbiter side
    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
        output mem_addr, mem_we, mem_wdata, cpu_starved
    );

    // Requester / RAM side
    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
        input  mem_addr, mem_we, mem_wdata, cpu_starved
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Screen-RAM arbiter: video has priority, the CPU is forced one slot after
// STARVE_MAX consecutive denied cycles. Grants and the RAM access happen in
// the same cycle; read data returns one cycle later and is steered to its
// owner by a small owner FSM.
module vga_mem_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 7
) (
    input  logic               clk,
    input  logic               resetn,
    vga_mem_arbiter_if.slave   bus
);
    // Wait counter is at least 3 bits wide, wider if STARVE_MAX needs it
    localparam int CW = (STARVE_MAX < 8) ? 3 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VID_RD = 2'd1,
        CPU_RD = 2'd2
    } owner_t;

    owner_t        state_r;
    owner_t        state_next_s;
    logic [CW-1:0] wait_cnt_r;
    logic          starved_r;
    logic [AW-1:0] addr_hold_r;

    logic          force_s;
    logic          vid_gnt_s;
    logic          cpu_gnt_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;
    logic          vid_rvalid_s;
    logic          cpu_rvalid_s;
    logic [DW-1:0] vid_rdata_s;
    logic [DW-1:0] cpu_rdata_s;

    assign force_s = bus.cpu_req && (wait_cnt_r == STARVE_LIM);

    // Grant decision: forced CPU slot first, then video, then CPU; nothing in reset
    always_comb begin
        vid_gnt_s = 1'b0;
        cpu_gnt_s = 1'b0;
        if (!resetn) begin
            vid_gnt_s = 1'b0;
            cpu_gnt_s = 1'b0;
        end else if (force_s) begin
            cpu_gnt_s = 1'b1;
        end else if (bus.vid_req) begin
            vid_gnt_s = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else begin
            vid_gnt_s = 1'b0;
            cpu_gnt_s = 1'b0;
        end
    end

    // RAM port drive: address follows the winner, otherwise holds the last one
    always_comb begin
        mem_we_s    = cpu_gnt_s & bus.cpu_we;
        mem_wdata_s = {DW{1'b0}};
        mem_addr_s  = addr_hold_r;
        if (vid_gnt_s) begin
            mem_addr_s = bus.vid_addr;
        end else if (cpu_gnt_s) begin
            mem_addr_s = bus.cpu_addr;
        end else begin
            mem_addr_s = addr_hold_r;
        end
        if (mem_we_s) begin
            mem_wdata_s = bus.cpu_wdata;
        end else begin
            mem_wdata_s = {DW{1'b0}};
        end
    end

    // Remember the last driven RAM address so it stays put while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_hold_r <= {AW{1'b0}};
        end else begin
            addr_hold_r <= mem_addr_s;
        end
    end

    // Count consecutive denied CPU cycles; a dropped request or a grant clears it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (!bus.cpu_req || cpu_gnt_s) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (wait_cnt_r < STARVE_LIM) begin
            wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky flag recording that a forced CPU slot has been taken
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starved_r <= 1'b0;
        end else if (force_s && cpu_gnt_s) begin
            starved_r <= 1'b1;
        end else begin
            starved_r <= starved_r;
        end
    end

    // Owner FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Owner of the read in flight is decided by this cycle's grant
    always_comb begin
        state_next_s = IDLE;
        if (vid_gnt_s) begin
            state_next_s = VID_RD;
        end else if (cpu_gnt_s && !bus.cpu_we) begin
            state_next_s = CPU_RD;
        end else begin
            state_next_s = IDLE;
        end
    end

    // Steer returning RAM data to the owner recorded by the FSM
    always_comb begin
        vid_rvalid_s = 1'b0;
        cpu_rvalid_s = 1'b0;
        vid_rdata_s  = {DW{1'b0}};
        cpu_rdata_s  = {DW{1'b0}};
        case (state_r)
            VID_RD: begin
                vid_rvalid_s = 1'b1;
                vid_rdata_s  = bus.mem_rdata;
            end
            CPU_RD: begin
                cpu_rvalid_s = 1'b1;
                cpu_rdata_s  = bus.mem_rdata;
            end
            default: begin
                vid_rvalid_s = 1'b0;
                cpu_rvalid_s = 1'b0;
            end
        endcase
    end

    assign bus.vid_gnt     = vid_gnt_s;
    assign bus.cpu_gnt     = cpu_gnt_s;
    assign bus.mem_we      = mem_we_s;
    assign bus.mem_addr    = mem_addr_s;
    assign bus.mem_wdata   = mem_wdata_s;
    assign bus.vid_rvalid  = vid_rvalid_s;
    assign bus.vid_rdata   = vid_rdata_s;
    assign bus.cpu_rvalid  = cpu_rvalid_s;
    assign bus.cpu_rdata   = cpu_rdata_s;
    assign bus.cpu_starved = starved_r;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter: grants and RAM port checked inline
// per scenario, read data checked by a scoreboard against expected values
// queued at grant time.
module tb_vga_mem_arbiter;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;
    bit   mon_en;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];

    // bench-side RAM model with 1-cycle read latency
    logic [15:0] ram   [0:4095];
    bit          ram_v [0:4095];
    // bench-side expectation of RAM contents
    logic [15:0] sh    [0:4095];
    bit          sh_v  [0:4095];

    vga_mem_arbiter_if #(.AW(12), .DW(16)) ifc ();

    vga_mem_arbiter #(.AW(12), .DW(16), .STARVE_MAX(7)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(input logic [11:0] a);
        return {4'hA, a} ^ 16'h0F0F;
    endfunction

    function automatic logic [15:0] exp_data(input logic [11:0] a);
        return sh_v[a] ? sh[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            ram[ifc.mem_addr]   <= ifc.mem_wdata;
            ram_v[ifc.mem_addr] <= 1'b1;
        end
        ifc.mem_rdata <= ram_v[ifc.mem_addr] ? ram[ifc.mem_addr] : pat(ifc.mem_addr);
    end

    // scoreboard consumer: rvalid must appear exactly when an entry is due
    always @(negedge clk) begin
        if (mon_en) begin
            logic ev;
            logic ec;
            ev = (vid_q.size() > 0) && (vid_q[0].due == cyc);
            ec = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
            checks++;
            if (ifc.vid_rvalid !== ev) begin
                errors++;
                $display("FAIL vid_rvalid cyc %0d: got %b expected %b", cyc, ifc.vid_rvalid, ev);
            end
            if (ev) begin
                checks++;
                if (ifc.vid_rdata !== vid_q[0].data) begin
                    errors++;
                    $display("FAIL vid_rdata cyc %0d: got %h expected %h", cyc, ifc.vid_rdata, vid_q[0].data);
                end
                void'(vid_q.pop_front());
            end
            checks++;
            if (ifc.cpu_rvalid !== ec) begin
                errors++;
                $display("FAIL cpu_rvalid cyc %0d: got %b expected %b", cyc, ifc.cpu_rvalid, ec);
            end
            if (ec) begin
                checks++;
                if (ifc.cpu_rdata !== cpu_q[0].data) begin
                    errors++;
                    $display("FAIL cpu_rdata cyc %0d: got %h expected %h", cyc, ifc.cpu_rdata, cpu_q[0].data);
                end
                void'(cpu_q.pop_front());
            end
        end
    end

    task automatic push_exp(input bit is_cpu, input logic [11:0] a);
        exp_t e;
        e.due  = cyc + 1;
        e.data = exp_data(a);
        if (is_cpu) cpu_q.push_back(e);
        else        vid_q.push_back(e);
    endtask

    task automatic drive(input logic vr, input logic [11:0] va, input logic cr,
                         input logic cw, input logic [11:0] ca, input logic [15:0] cd);
        @(posedge clk);
        #1;
        ifc.vid_req   = vr;
        ifc.vid_addr  = va;
        ifc.cpu_req   = cr;
        ifc.cpu_we    = cw;
        ifc.cpu_addr  = ca;
        ifc.cpu_wdata = cd;
        #1;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        ifc.vid_req   = 1'b1;
        ifc.vid_addr  = 12'h0AA;
        ifc.cpu_req   = 1'b1;
        ifc.cpu_we    = 1'b1;
        ifc.cpu_addr  = 12'h0BB;
        ifc.cpu_wdata = 16'hDEAD;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2;
            mon_en = 1'b1;
            checks++;
            if (ifc.vid_gnt !== 1'b0 || ifc.cpu_gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: got vid %b cpu %b expected 0 0", ifc.vid_gnt, ifc.cpu_gnt);
            end
            checks++;
            if (ifc.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem_we: got %b expected 0", ifc.mem_we);
            end
            checks++;
            if (ifc.mem_addr !== 12'h000) begin
                errors++;
                $display("FAIL reset_mem_addr: got %h expected 000", ifc.mem_addr);
            end
            checks++;
            if (ifc.cpu_starved !== 1'b0) begin
                errors++;
                $display("FAIL reset_starved: got %b expected 0", ifc.cpu_starved);
            end
        end
        @(posedge clk);
        #1;
        resetn      = 1'b1;
        ifc.vid_req = 1'b0;
        ifc.cpu_req = 1'b0;
        ifc.cpu_we  = 1'b0;
    endtask

    task automatic test_write_read();
        drive(1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 16'h1234);
        checks++;
        if (ifc.cpu_gnt !== 1'b1 || ifc.vid_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wr_gnt: got cpu %b vid %b expected 1 0", ifc.cpu_gnt, ifc.vid_gnt);
        end
        checks++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_wdata !== 16'h1234 || ifc.mem_addr !== 12'h010) begin
            errors++;
            $display("FAIL wr_port: got we %b wdata %h addr %h expected 1 1234 010",
                     ifc.mem_we, ifc.mem_wdata, ifc.mem_addr);
        end
        sh[12'h010]   = 16'h1234;
        sh_v[12'h010] = 1'b1;

        drive(1'b0, 12'h000, 1'b1, 1'b0, 12'h010, 16'hFFFF);
        checks++;
        if (ifc.cpu_gnt !== 1'b1 || ifc.mem_we !== 1'b0 || ifc.mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL rd_port: got gnt %b we %b wdata %h expected 1 0 0000",
                     ifc.cpu_gnt, ifc.mem_we, ifc.mem_wdata);
        end
        push_exp(1'b1, 12'h010);

        drive(1'b0, 12'h3FF, 1'b0, 1'b0, 12'h3FE, 16'h0000);
        checks++;
        if (ifc.vid_gnt !== 1'b0 || ifc.cpu_gnt !== 1'b0 || ifc.mem_addr !== 12'h010) begin
            errors++;
            $display("FAIL idle_hold: got vid %b cpu %b addr %h expected 0 0 010",
                     ifc.vid_gnt, ifc.cpu_gnt, ifc.mem_addr);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) begin
            logic is_cpu;
            logic [11:0] a;
            is_cpu = (i % 2) == 1;
            a = is_cpu ? (12'h200 + 12'(i)) : (12'h100 + 12'(i));
            drive(!is_cpu, a, is_cpu, 1'b0, a, 16'h0000);
            checks++;
            if (ifc.vid_gnt !== !is_cpu || ifc.cpu_gnt !== is_cpu || ifc.mem_addr !== a) begin
                errors++;
                $display("FAIL alt_%0d: got vid %b cpu %b addr %h expected %b %b %h",
                         i, ifc.vid_gnt, ifc.cpu_gnt, ifc.mem_addr, !is_cpu, is_cpu, a);
            end
            push_exp(is_cpu, a);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    task automatic test_drop();
        for (int i = 0; i < 11; i++) begin
            logic [11:0] a;
            logic cr;
            a  = 12'h300 + 12'(i);
            cr = (i != 3);
            drive(1'b1, a, cr, 1'b0, 12'h055, 16'h0000);
            checks++;
            if (ifc.vid_gnt !== 1'b1 || ifc.cpu_gnt !== 1'b0) begin
                errors++;
                $display("FAIL drop_%0d: got vid %b cpu %b expected 1 0", i, ifc.vid_gnt, ifc.cpu_gnt);
            end
            push_exp(1'b0, a);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checks++;
        if (ifc.cpu_starved !== 1'b0) begin
            errors++;
            $display("FAIL drop_starved: got %b expected 0", ifc.cpu_starved);
        end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 8; i++) begin
            logic [11:0] a;
            logic forced;
            a = 12'h400 + 12'(i);
            forced = (i == 7);
            drive(1'b1, a, 1'b1, 1'b0, 12'h066, 16'h0000);
            checks++;
            if (ifc.vid_gnt !== !forced || ifc.cpu_gnt !== forced) begin
                errors++;
                $display("FAIL starve_%0d: got vid %b cpu %b expected %b %b",
                         i, ifc.vid_gnt, ifc.cpu_gnt, !forced, forced);
            end
            checks++;
            if (ifc.mem_addr !== (forced ? 12'h066 : a) || ifc.cpu_starved !== 1'b0) begin
                errors++;
                $display("FAIL starve_port_%0d: got addr %h starved %b", i, ifc.mem_addr, ifc.cpu_starved);
            end
            push_exp(forced, forced ? 12'h066 : a);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
        checks++;
        if (ifc.cpu_starved !== 1'b1) begin
            errors++;
            $display("FAIL starve_flag: got %b expected 1", ifc.cpu_starved);
        end
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 12'h500, 1'b0, 1'b0, 12'h000, 16'h0000);
        checks++;
        if (ifc.vid_gnt !== 1'b1) begin
            errors++;
            $display("FAIL inflight_gnt: got %b expected 1", ifc.vid_gnt);
        end
        // no push: the read is discarded by reset
        @(posedge clk);
        #1;
        resetn      = 1'b0;
        ifc.vid_req = 1'b0;
        #1;
        checks++;
        if (ifc.vid_rvalid !== 1'b0 || ifc.cpu_starved !== 1'b0 || ifc.mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL inflight_rst: got rvalid %b starved %b addr %h expected 0 0 000",
                     ifc.vid_rvalid, ifc.cpu_starved, ifc.mem_addr);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
            checks++;
            if (ifc.vid_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_post_%0d: got rvalid %b expected 0", k, ifc.vid_rvalid);
            end
        end
        drive(1'b1, 12'h501, 1'b0, 1'b0, 12'h000, 16'h0000);
        checks++;
        if (ifc.vid_gnt !== 1'b1 || ifc.mem_addr !== 12'h501) begin
            errors++;
            $display("FAIL post_rst_gnt: got %b addr %h expected 1 501", ifc.vid_gnt, ifc.mem_addr);
        end
        push_exp(1'b0, 12'h501);
        drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        test_reset();
        test_write_read();
        test_alternate();
        test_drop();
        test_starve();
        test_reset_inflight();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (vid_q.size() != 0 || cpu_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", vid_q.size(), cpu_q.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
